// File: rtl/vend_dispense_ctrl.sv
// ----------------------------------------------------------------------------
// vend_dispense_ctrl
//
// Sits downstream of the coin-accumulator FSM. It turns a registered vend flag
// plus a change code (number of 5 rs coins, 0..4) into a product-release
// req/ack handshake with the motor, followed by timed ejector pulses, one
// coin at a time. One further request can wait in a pending slot while a
// job runs. A request that arrives while that slot is still occupied is
// dropped and raises the sticky overflow flag. A motor that never answers
// within ACK_TIMEOUT cycles latches the FSM in FAULT until rst.
//
// Ports:
//   clk         clock
//   rst         synchronous, active-high reset
//   vend_in     product-release request from the accumulator
//   change_in   coins to return (0..4); codes 5..7 are never captured
//   prod_ack    motor acknowledge (level)
//   prod_req    motor request (registered)
//   coin_eject  ejector solenoid drive (registered)
//   busy        FSM not idle, or a request is pending (registered)
//   fault       sticky acknowledge-timeout flag (registered)
//   overflow    sticky dropped-request flag (registered)
//   vend_count  products released, wraps modulo 2^CNT_W
//   coin_count  coins ejected, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module vend_dispense_ctrl #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int ACK_TIMEOUT  = 1000,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vend_in,
    input  logic [2:0]       change_in,
    input  logic             prod_ack,
    output logic             prod_req,
    output logic             coin_eject,
    output logic             busy,
    output logic             fault,
    output logic             overflow,
    output logic [CNT_W-1:0] vend_count,
    output logic [CNT_W-1:0] coin_count
);

    localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [PH_W-1:0]  PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PROD_REQ = 3'd1,
        ST_PROD_REL = 3'd2,
        ST_COIN_ON  = 3'd3,
        ST_COIN_GAP = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    state_t             state_r, state_nx_s;

    logic [3:0]         prev_sample_r;
    logic [3:0]         sample_s;
    logic               capture_s;
    logic               load_s;
    logic               drop_s;

    logic               pend_valid_r, pend_valid_nx_s;
    logic               pend_vend_r,  pend_vend_nx_s;
    logic [2:0]         pend_change_r, pend_change_nx_s;

    logic [2:0]         rem_r, rem_nx_s;
    logic [TMO_W-1:0]   tmo_r, tmo_nx_s;
    logic [PH_W-1:0]    ph_r,  ph_nx_s;
    logic [CNT_W-1:0]   vend_count_r, vend_count_nx_s;
    logic [CNT_W-1:0]   coin_count_r, coin_count_nx_s;

    logic               prod_req_r;
    logic               coin_eject_r;
    logic               busy_r;
    logic               fault_r;
    logic               overflow_r;

    // A capture needs a non-empty, legal request that differs from last cycle's
    // sample, so a level held by the accumulator is taken only once.
    assign sample_s  = {vend_in, change_in};
    assign capture_s = (vend_in || (change_in != 3'd0)) && (change_in <= 3'd4) &&
                       (sample_s != prev_sample_r) && (state_r != ST_FAULT);
    assign load_s    = (state_r == ST_IDLE) && pend_valid_r;

    // Pending slot: a capture is accepted when the slot is empty or is being
    // handed to the FSM this very cycle; otherwise it is dropped.
    always_comb begin
        pend_valid_nx_s  = pend_valid_r;
        pend_vend_nx_s   = pend_vend_r;
        pend_change_nx_s = pend_change_r;
        drop_s           = 1'b0;
        if (state_r == ST_FAULT) begin
            pend_valid_nx_s = 1'b0;
        end else if (capture_s && (!pend_valid_r || load_s)) begin
            pend_valid_nx_s  = 1'b1;
            pend_vend_nx_s   = vend_in;
            pend_change_nx_s = change_in;
        end else if (capture_s) begin
            drop_s = 1'b1;
        end else if (load_s) begin
            pend_valid_nx_s = 1'b0;
        end else begin
            pend_valid_nx_s = pend_valid_r;
        end
    end

    // Next-state and datapath logic. Coin count advances on the edge that
    // enters COIN_ON, so it rises together with coin_eject.
    always_comb begin
        state_nx_s      = state_r;
        rem_nx_s        = rem_r;
        tmo_nx_s        = tmo_r;
        ph_nx_s         = ph_r;
        vend_count_nx_s = vend_count_r;
        coin_count_nx_s = coin_count_r;
        case (state_r)
            ST_IDLE: begin
                tmo_nx_s = '0;
                ph_nx_s  = '0;
                if (pend_valid_r) begin
                    rem_nx_s = pend_change_r;
                    if (pend_vend_r) begin
                        state_nx_s = ST_PROD_REQ;
                    end else begin
                        state_nx_s      = ST_COIN_ON;
                        coin_count_nx_s = coin_count_r + CNT_ONE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PROD_REQ: begin
                // Ack is tested first so a simultaneous timeout loses.
                if (prod_ack) begin
                    state_nx_s      = ST_PROD_REL;
                    tmo_nx_s        = '0;
                    vend_count_nx_s = vend_count_r + CNT_ONE;
                end else if (tmo_r == TMO_LAST) begin
                    state_nx_s = ST_FAULT;
                end else begin
                    tmo_nx_s = tmo_r + TMO_W'(1);
                end
            end
            ST_PROD_REL: begin
                if (!prod_ack) begin
                    tmo_nx_s = '0;
                    ph_nx_s  = '0;
                    if (rem_r != 3'd0) begin
                        state_nx_s      = ST_COIN_ON;
                        coin_count_nx_s = coin_count_r + CNT_ONE;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_nx_s = ST_FAULT;
                end else begin
                    tmo_nx_s = tmo_r + TMO_W'(1);
                end
            end
            ST_COIN_ON: begin
                if (ph_r == PULSE_LAST) begin
                    state_nx_s = ST_COIN_GAP;
                    ph_nx_s    = '0;
                end else begin
                    ph_nx_s = ph_r + PH_W'(1);
                end
            end
            ST_COIN_GAP: begin
                if (ph_r == GAP_LAST) begin
                    ph_nx_s  = '0;
                    rem_nx_s = rem_r - 3'd1;
                    if (rem_r == 3'd1) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s      = ST_COIN_ON;
                        coin_count_nx_s = coin_count_r + CNT_ONE;
                    end
                end else begin
                    ph_nx_s = ph_r + PH_W'(1);
                end
            end
            ST_FAULT: begin
                state_nx_s = ST_FAULT;
            end
            default: begin
                state_nx_s = ST_FAULT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath, pending slot, counters and registered outputs. Outputs are
    // decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample_r <= 4'd0;
            pend_valid_r  <= 1'b0;
            pend_vend_r   <= 1'b0;
            pend_change_r <= 3'd0;
            rem_r         <= 3'd0;
            tmo_r         <= '0;
            ph_r          <= '0;
            vend_count_r  <= '0;
            coin_count_r  <= '0;
            prod_req_r    <= 1'b0;
            coin_eject_r  <= 1'b0;
            busy_r        <= 1'b0;
            fault_r       <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            prev_sample_r <= sample_s;
            pend_valid_r  <= pend_valid_nx_s;
            pend_vend_r   <= pend_vend_nx_s;
            pend_change_r <= pend_change_nx_s;
            rem_r         <= rem_nx_s;
            tmo_r         <= tmo_nx_s;
            ph_r          <= ph_nx_s;
            vend_count_r  <= vend_count_nx_s;
            coin_count_r  <= coin_count_nx_s;
            prod_req_r    <= (state_nx_s == ST_PROD_REQ);
            coin_eject_r  <= (state_nx_s == ST_COIN_ON);
            busy_r        <= (state_nx_s != ST_IDLE) || pend_valid_nx_s;
            fault_r       <= (state_nx_s == ST_FAULT);
            overflow_r    <= overflow_r || drop_s;
        end
    end

    assign prod_req   = prod_req_r;
    assign coin_eject = coin_eject_r;
    assign busy       = busy_r;
    assign fault      = fault_r;
    assign overflow   = overflow_r;
    assign vend_count = vend_count_r;
    assign coin_count = coin_count_r;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vend_dispense_ctrl
//
// Directed bench for vend_dispense_ctrl. Each driven request pushes the
// output events it should cause (product request, coin pulse) onto a
// scoreboard queue; a negedge monitor pops one entry per observed rising
// edge of prod_req / coin_eject and also measures pulse and gap lengths.
// ----------------------------------------------------------------------------
module tb_vend_dispense_ctrl;

    localparam int PULSE = 4;
    localparam int GAP   = 4;
    localparam int TMO   = 1000;
    localparam int CW    = 8;
    localparam int EV_P  = 1;
    localparam int EV_C  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vend_in = 1'b0;
    logic [2:0]    change_in = 3'd0;
    logic          prod_ack = 1'b0;
    logic          prod_req, coin_eject, busy, fault, overflow;
    logic [CW-1:0] vend_count, coin_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int sb[$];

    // monitor state
    logic prev_req  = 1'b0;
    logic prev_coin = 1'b0;
    int   hi_len = 0;
    int   lo_len = 0;
    bit   armed  = 1'b0;
    bit   gap_ok = 1'b0;

    vend_dispense_ctrl #(
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP),
        .ACK_TIMEOUT  (TMO),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .vend_in    (vend_in),
        .change_in  (change_in),
        .prod_ack   (prod_ack),
        .prod_req   (prod_req),
        .coin_eject (coin_eject),
        .busy       (busy),
        .fault      (fault),
        .overflow   (overflow),
        .vend_count (vend_count),
        .coin_count (coin_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    task automatic sb_pop(input int kind);
        int want;
        if (sb.size() == 0) begin
            check("sb_unexpected_event", kind, 0);
        end else begin
            want = sb.pop_front();
            check("sb_event_kind", kind, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        vend_in   = 1'b0;
        change_in = 3'd0;
        prod_ack  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        sb.delete();
        check("rst_prod_req", prod_req, 0);
        check("rst_coin_eject", coin_eject, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_overflow", overflow, 0);
        check("rst_vend_count", vend_count, 0);
        check("rst_coin_count", coin_count, 0);
    endtask

    // Drive one request for exactly one cycle.
    task automatic send(input logic v, input logic [2:0] c);
        vend_in   = v;
        change_in = c;
        tick();
        vend_in   = 1'b0;
        change_in = 3'd0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, busy, 0);
    endtask

    // Wait for the motor request, hold off d cycles, then ack and release.
    task automatic do_ack(input string tag, input int d);
        int n = 0;
        while (prod_req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, prod_req, 1);
        repeat (d) tick();
        prod_ack = 1'b1;
        n = 0;
        while (prod_req !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        prod_ack = 1'b0;
    endtask

    // Output monitor: one scoreboard pop per rising edge, plus pulse/gap timing.
    always @(negedge clk) begin
        if (rst) begin
            hi_len = 0;
            lo_len = 0;
            armed  = 1'b0;
            gap_ok = 1'b0;
        end else begin
            if (prod_req === 1'b1 && prev_req !== 1'b1) sb_pop(EV_P);
            if (coin_eject === 1'b1) begin
                if (prev_coin !== 1'b1) begin
                    sb_pop(EV_C);
                    if (gap_ok) check("gap_len", lo_len, GAP);
                    armed  = 1'b1;
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (prev_coin === 1'b1 && armed) begin
                    check("pulse_len", hi_len, PULSE);
                    gap_ok = 1'b1;
                    lo_len = 0;
                end
                lo_len++;
                if (busy !== 1'b1) gap_ok = 1'b0;
            end
        end
        prev_req  = prod_req;
        prev_coin = coin_eject;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // 1: vend + 2 coins, ack after 3 cycles
        reset_dut();
        sb.push_back(EV_P); sb.push_back(EV_C); sb.push_back(EV_C);
        vend_in = 1'b1; change_in = 3'd2;
        tick();
        check("t1_busy_n1", busy, 1);
        check("t1_req_n1", prod_req, 0);
        vend_in = 1'b0; change_in = 3'd0;
        tick();
        check("t1_req_n2", prod_req, 1);
        repeat (3) tick();
        check("t1_req_hold", prod_req, 1);
        prod_ack = 1'b1;
        tick();
        check("t1_req_drop", prod_req, 0);
        check("t1_vend_count_ack", vend_count, 1);
        check("t1_no_coin_before_release", coin_eject, 0);
        prod_ack = 1'b0;
        tick();
        check("t1_coin_after_release", coin_eject, 1);
        wait_idle("t1_idle", 200);
        check("t1_vend_count", vend_count, 1);
        check("t1_coin_count", coin_count, 2);
        check("t1_sb_empty", sb.size(), 0);

        // 2: refund of 3 coins, no product request
        reset_dut();
        sb.push_back(EV_C); sb.push_back(EV_C); sb.push_back(EV_C);
        send(1'b0, 3'd3);
        wait_idle("t2_idle", 200);
        check("t2_vend_count", vend_count, 0);
        check("t2_coin_count", coin_count, 3);
        check("t2_sb_empty", sb.size(), 0);

        // 3: ack never arrives
        reset_dut();
        sb.push_back(EV_P);
        send(1'b1, 3'd0);
        tick();
        check("t3_req_rise", prod_req, 1);
        n = 0;
        while (fault !== 1'b1 && n < TMO + 100) begin
            tick();
            n++;
        end
        check("t3_fault_latency", n, TMO);
        check("t3_fault", fault, 1);
        check("t3_req_low", prod_req, 0);
        send(1'b0, 3'd1);
        repeat (3) tick();
        check("t3_ignored_coin", coin_eject, 0);
        check("t3_ignored_overflow", overflow, 0);
        check("t3_busy_in_fault", busy, 1);
        check("t3_fault_sticky", fault, 1);
        check("t3_sb_empty", sb.size(), 0);
        reset_dut();
        check("t3_fault_cleared", fault, 0);

        // 4: buffered job B runs after A, job C dropped
        sb.push_back(EV_P); sb.push_back(EV_C); sb.push_back(EV_C);
        sb.push_back(EV_P);
        send(1'b1, 3'd2);
        do_ack("t4_a_req", 2);
        n = 0;
        while (coin_eject !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("t4_a_ejecting", coin_eject, 1);
        send(1'b1, 3'd0);
        tick();
        check("t4_no_overflow_yet", overflow, 0);
        send(1'b0, 3'd1);
        check("t4_overflow", overflow, 1);
        do_ack("t4_b_req", 2);
        wait_idle("t4_idle", 200);
        check("t4_vend_count", vend_count, 2);
        check("t4_coin_count", coin_count, 2);
        check("t4_overflow_sticky", overflow, 1);
        check("t4_sb_empty", sb.size(), 0);

        // 5: invalid code ignored, then one coin
        reset_dut();
        vend_in = 1'b0; change_in = 3'd6;
        repeat (2) tick();
        check("t5_invalid_busy", busy, 0);
        sb.push_back(EV_C);
        change_in = 3'd1;
        tick();
        change_in = 3'd0;
        check("t5_busy", busy, 1);
        wait_idle("t5_idle", 100);
        check("t5_coin_count", coin_count, 1);
        check("t5_vend_count", vend_count, 0);
        check("t5_sb_empty", sb.size(), 0);

        // 6: reset in the 2nd cycle of a coin pulse
        reset_dut();
        sb.push_back(EV_C); sb.push_back(EV_C);
        send(1'b0, 3'd2);
        n = 0;
        while (coin_eject !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("t6_pulse_start", coin_eject, 1);
        tick();
        check("t6_coin_count_mid", coin_count, 1);
        rst = 1'b1;
        tick();
        check("t6_coin_dropped", coin_eject, 0);
        check("t6_busy_dropped", busy, 0);
        check("t6_coin_count_cleared", coin_count, 0);
        rst = 1'b0;
        sb.delete();
        sb.push_back(EV_P); sb.push_back(EV_C);
        send(1'b1, 3'd1);
        do_ack("t6_req", 1);
        wait_idle("t6_idle", 200);
        check("t6_vend_count", vend_count, 1);
        check("t6_coin_count", coin_count, 1);
        check("t6_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Downstream of the coin-accumulator FSM; consumes its registered vend flag and 3-bit change code.
- Change is in units of one 5 rs coin, 0..4.
- Drives the product-release motor through a req/ack handshake and the coin ejector one coin at a time with timed pulses.
- Buffers one request while busy, flags overflow, and faults on a missing motor acknowledge.

Parameters:
- PULSE_CYCLES, 4: coin_eject high time per coin, in cycles, ≥1.
- GAP_CYCLES, 4: coin_eject low time between coins, in cycles, ≥1.
- ACK_TIMEOUT, 1000: maximum cycles prod_req may wait for prod_ack before fault.
- CNT_W, 8: width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; clock clk
- vend_in  in  1  product-release request from the accumulator FSM
- change_in  in  3  coins to return, 0..4; codes 5..7 are invalid
- prod_ack  in  1  motor acknowledge, level
- prod_req  out  1  motor request, registered
- coin_eject  out  1  ejector solenoid, registered
- busy  out  1  high whenever the FSM is not in IDLE or the pending slot is valid
- fault  out  1  sticky; cleared only by rst
- overflow  out  1  sticky; a request was dropped
- vend_count  out  CNT_W  products released; wraps
- coin_count  out  CNT_W  coins ejected; wraps

Behaviour:
- Reset: all outputs 0, counters 0, FSM to IDLE, pending slot empty, prev_sample = 0.
- Capture:
  - prev_sample registers {vend_in, change_in} every cycle.
  - A request is captured in cycle N when (vend_in=1 or change_in≠0), change_in≤4, and {vend_in, change_in}≠prev_sample.
  - A capture writes {vend, change} into the pending slot.
  - Codes 5..7 are never captured, but prev_sample still updates.
- Pending slot:
  - Holds one entry.
  - If the slot is valid and is not being loaded this cycle, a capture is dropped and overflow is set.
  - If the slot is loaded by the FSM in the same cycle as a capture, the capture is accepted.
- FSM states: IDLE, PROD_REQ, PROD_REL, COIN_ON, COIN_GAP, FAULT.
- IDLE:
  - If the pending slot is valid, load it into the job registers (vend_j, rem = change) and clear the slot.
  - Next state is PROD_REQ if vend_j=1, else COIN_ON.
  - Latency: capture in cycle N gives pending valid at N+1; prod_req or coin_eject goes high at N+2.
- PROD_REQ:
  - prod_req=1; the timeout counter increments each cycle.
  - prod_ack=1 → prod_req=0, vend_count+1, go to PROD_REL.
  - If the counter reaches ACK_TIMEOUT with no ack → FAULT.
  - If ack and timeout occur in the same cycle, ack wins.
- PROD_REL:
  - prod_req=0; wait for prod_ack=0, with the timeout counter restarted.
  - Then go to COIN_ON if rem>0, else IDLE.
  - Timeout here → FAULT.
- COIN_ON:
  - coin_eject=1 for exactly PULSE_CYCLES cycles.
  - coin_count increments on the first cycle of each pulse.
  - Then go to COIN_GAP.
- COIN_GAP:
  - coin_eject=0 for exactly GAP_CYCLES cycles, then rem−1.
  - If rem becomes 0 → IDLE, else → COIN_ON.
- FAULT:
  - prod_req=0, coin_eject=0, fault=1, busy=1.
  - The pending slot is cleared, captures are ignored, and the FSM stays here until rst.
- Job order: product release always precedes change ejection for the same job.
- vend_in=0 with change_in≠0 (refund) runs coins only.
- rst mid-operation: outputs drop on the next clock edge. The job, pending slot, and sticky flags are lost; no partial coin count is preserved.
- Counters wrap modulo 2^CNT_W; overflow and fault never self-clear.

Test Plan:
1. After reset, vend_in=1 and change_in=2 for one cycle at N → prod_req=1 at N+2. Ack after 3 cycles, then release → two coin_eject pulses of 4 high / 4 low. Result: vend_count=1, coin_count=2, then busy=0.
2. vend_in=0, change_in=3 (refund) → prod_req never asserts; three pulses; coin_count=3, vend_count=0.
3. prod_ack held 0 with ACK_TIMEOUT=1000 → fault=1 exactly 1000 cycles after prod_req rises. prod_req=0 afterwards; new captures are ignored; rst clears fault.
4. While the first job is ejecting, capture job B (vend only), then job C → B runs after the first job finishes. C is dropped and overflow=1.
5. change_in=6 with vend_in=0 → no capture, busy stays 0. Then change_in=1 → one pulse, coin_count=1.
6. Assert rst during the 2nd cycle of a coin pulse → coin_eject=0, busy=0, counters=0 on the next edge; a new request then runs normally.
